// File: rtl/wf_pkg.sv
// Shared types, encodings and saturating arithmetic helpers for the wavefront aligner.
package wf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_GLOBAL = 1'b0,
    MODE_SEMI   = 1'b1
  } mode_e;

  localparam logic [2:0] NT_A = 3'd0;
  localparam logic [2:0] NT_C = 3'd1;
  localparam logic [2:0] NT_G = 3'd2;
  localparam logic [2:0] NT_T = 3'd3;
  localparam logic [2:0] NT_N = 3'd4;

  // Sum clamped to 2^w-1; operands are assumed already below that ceiling.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    return (s > mx) ? mx[31:0] : s[31:0];
  endfunction

  function automatic logic sat_hit(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    return s > mx;
  endfunction

endpackage

// File: rtl/wf_align_array_if.sv
// Host-side bundle of the aligner: job control, reference stream and result.
interface wf_align_array_if #(
  parameter int N_PE    = 4,
  parameter int SYM_W   = 3,
  parameter int SCORE_W = 8
);
  // Reference beat transfers on a rising edge where ref_valid && ref_ready; the
  // source may change ref_sym/ref_last freely while ref_valid is low.
  logic                    start;
  logic                    mode;
  logic [N_PE*SYM_W-1:0]   query;
  logic                    ref_valid;
  logic [SYM_W-1:0]        ref_sym;
  logic                    ref_last;
  logic                    ref_ready;
  logic                    busy;
  logic                    done;
  logic [SCORE_W-1:0]      score;
  logic                    sat;
  wf_pkg::state_e          state_dbg;

  modport master (
    output start, mode, query, ref_valid, ref_sym, ref_last,
    input  ref_ready, busy, done, score, sat, state_dbg
  );

  modport slave (
    input  start, mode, query, ref_valid, ref_sym, ref_last,
    output ref_ready, busy, done, score, sat, state_dbg
  );
endinterface

// File: rtl/wf_pe.sv
// One systolic cell: computes H[i][j+1] from the left neighbour and its own up value.
module wf_pe
  import wf_pkg::*;
#(
  parameter int SYM_W    = 3,
  parameter int SCORE_W  = 8,
  parameter int MIS_COST = 1,
  parameter int GAP_COST = 1,
  parameter int INIT_UP  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic [SYM_W-1:0]   q_sym_i,
  input  logic               in_valid_i,
  input  logic [SYM_W-1:0]   in_sym_i,
  input  logic               in_last_i,
  input  logic [SCORE_W-1:0] in_curr_i,
  input  logic [SCORE_W-1:0] in_prev_i,
  output logic               out_valid_o,
  output logic [SYM_W-1:0]   out_sym_o,
  output logic               out_last_o,
  output logic [SCORE_W-1:0] out_curr_o,
  output logic [SCORE_W-1:0] out_prev_o,
  output logic               sat_hit_o
);

  logic [SYM_W-1:0]   q_sym_q;
  logic [SCORE_W-1:0] up_q;
  logic               valid_q;
  logic [SYM_W-1:0]   sym_q;
  logic               last_q;
  logic [SCORE_W-1:0] curr_q;
  logic [SCORE_W-1:0] prev_q;

  logic [31:0]        mis;
  logic [SCORE_W-1:0] diag, up, left, cell_d;

  always_comb begin
    mis  = (in_sym_i != q_sym_q) ? 32'(MIS_COST) : 32'd0;
    diag = SCORE_W'(sat_add(32'(in_prev_i), mis, SCORE_W));
    up   = SCORE_W'(sat_add(32'(up_q), 32'(GAP_COST), SCORE_W));
    left = SCORE_W'(sat_add(32'(in_curr_i), 32'(GAP_COST), SCORE_W));
    cell_d = diag;
    if (up < cell_d) cell_d = up;
    if (left < cell_d) cell_d = left;
    sat_hit_o = in_valid_i && (sat_hit(32'(in_prev_i), mis, SCORE_W) ||
                               sat_hit(32'(up_q), 32'(GAP_COST), SCORE_W) ||
                               sat_hit(32'(in_curr_i), 32'(GAP_COST), SCORE_W));
  end

  // A bubble only clears the forwarded valid; every data register holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_sym_q <= '0;
      up_q    <= '0;
      valid_q <= 1'b0;
      sym_q   <= '0;
      last_q  <= 1'b0;
      curr_q  <= '0;
      prev_q  <= '0;
    end else if (clr_i) begin
      q_sym_q <= q_sym_i;
      up_q    <= SCORE_W'(INIT_UP);
      valid_q <= 1'b0;
      sym_q   <= '0;
      last_q  <= 1'b0;
      curr_q  <= '0;
      prev_q  <= '0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        sym_q  <= in_sym_i;
        last_q <= in_last_i;
        curr_q <= cell_d;
        prev_q <= up_q;
        up_q   <= cell_d;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_sym_o   = sym_q;
  assign out_last_o  = last_q;
  assign out_curr_o  = curr_q;
  assign out_prev_o  = prev_q;

endmodule

// File: rtl/wf_align_array.sv
// Wavefront aligner top: job FSM, left-boundary generator, PE chain and result capture.
module wf_align_array
  import wf_pkg::*;
#(
  parameter int N_PE     = 4,
  parameter int SYM_W    = 3,
  parameter int SCORE_W  = 8,
  parameter int MAX_REF  = 255,
  parameter int MIS_COST = 1,
  parameter int GAP_COST = 1
) (
  input  logic             clk,
  input  logic             reset,
  wf_align_array_if.slave  bus
);

  localparam int RW      = $clog2(MAX_REF + 1);
  localparam int DW      = (N_PE > 2) ? $clog2(N_PE - 1) : 1;
  localparam int SMAX    = (1 << SCORE_W) - 1;
  localparam bit TOP_SAT = (N_PE * GAP_COST) > SMAX;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [RW-1:0]      row_q, row_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [SCORE_W-1:0] left_q, left_d;
  logic [SCORE_W-1:0] min_q, min_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               done_q, done_d;
  logic               sat_q, sat_d;

  logic               start_ok, acc, at_max, final_beat, left_hit;
  logic [SCORE_W-1:0] curr_left;

  logic               v_c   [N_PE+1];
  logic               l_c   [N_PE+1];
  logic [SYM_W-1:0]   s_c   [N_PE+1];
  logic [SCORE_W-1:0] cur_c [N_PE+1];
  logic [SCORE_W-1:0] prv_c [N_PE+1];
  logic [N_PE-1:0]    pe_hit;

  assign start_ok   = bus.start && (state_q == ST_IDLE);
  assign acc        = bus.ref_valid && (state_q == ST_RUN);
  assign at_max     = (row_q == RW'(MAX_REF - 1));
  assign final_beat = acc && (bus.ref_last || at_max);

  // Left boundary is accumulated one GAP_COST per row instead of multiplied.
  assign curr_left = (mode_q == MODE_SEMI) ? '0 :
                     SCORE_W'(sat_add(32'(left_q), 32'(GAP_COST), SCORE_W));
  assign left_hit  = (mode_q == MODE_GLOBAL) &&
                     sat_hit(32'(left_q), 32'(GAP_COST), SCORE_W);

  assign v_c[0]   = acc;
  assign s_c[0]   = bus.ref_sym;
  assign l_c[0]   = final_beat;
  assign cur_c[0] = curr_left;
  assign prv_c[0] = left_q;

  for (genvar j = 0; j < N_PE; j++) begin : g_pe
    localparam int RAW = (j + 1) * GAP_COST;
    wf_pe #(
      .SYM_W    (SYM_W),
      .SCORE_W  (SCORE_W),
      .MIS_COST (MIS_COST),
      .GAP_COST (GAP_COST),
      .INIT_UP  ((RAW > SMAX) ? SMAX : RAW)
    ) u_pe (
      .clk         (clk),
      .reset       (reset),
      .clr_i       (start_ok),
      .q_sym_i     (bus.query[j*SYM_W +: SYM_W]),
      .in_valid_i  (v_c[j]),
      .in_sym_i    (s_c[j]),
      .in_last_i   (l_c[j]),
      .in_curr_i   (cur_c[j]),
      .in_prev_i   (prv_c[j]),
      .out_valid_o (v_c[j+1]),
      .out_sym_o   (s_c[j+1]),
      .out_last_o  (l_c[j+1]),
      .out_curr_o  (cur_c[j+1]),
      .out_prev_o  (prv_c[j+1]),
      .sat_hit_o   (pe_hit[j])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN:   if (final_beat) state_d = (N_PE > 1) ? ST_DRAIN : ST_DONE;
      ST_DRAIN: if (drain_q == DW'(N_PE - 2)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ref_ready = (state_q == ST_RUN);
    bus.busy      = (state_q != ST_IDLE);
    bus.state_dbg = state_q;
    bus.done      = done_q;
    bus.score     = score_q;
    bus.sat       = sat_q;
  end

  // The last row leaves the final PE during DONE, so it is folded in combinationally there.
  always_comb begin
    row_d   = row_q;
    left_d  = left_q;
    mode_d  = mode_q;
    drain_d = drain_q;
    min_d   = min_q;
    score_d = score_q;
    done_d  = 1'b0;
    sat_d   = sat_q;
    if (start_ok) begin
      row_d   = '0;
      left_d  = '0;
      mode_d  = mode_e'(bus.mode);
      drain_d = '0;
      min_d   = '1;
      score_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (acc) begin
        if (row_q != RW'(MAX_REF)) row_d = row_q + RW'(1);
        left_d = curr_left;
        if (left_hit || at_max || TOP_SAT) sat_d = 1'b1;
      end
      if (|pe_hit) sat_d = 1'b1;
      if (v_c[N_PE] && (cur_c[N_PE] < min_q)) min_d = cur_c[N_PE];
      if (state_q == ST_DRAIN) drain_d = drain_q + DW'(1);
      if (state_q == ST_DONE) begin
        done_d  = 1'b1;
        score_d = (mode_q == MODE_SEMI) ? min_d : cur_c[N_PE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q   <= '0;
      left_q  <= '0;
      mode_q  <= MODE_GLOBAL;
      drain_q <= '0;
      min_q   <= '0;
      score_q <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      row_q   <= row_d;
      left_q  <= left_d;
      mode_q  <= mode_d;
      drain_q <= drain_d;
      min_q   <= min_d;
      score_q <= score_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_wf_align_array.sv
// Directed bench for wf_align_array: three parameter variants share one stimulus stream.
module tb_wf_align_array;
  import wf_pkg::*;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        d_start = 1'b0;
  logic        d_mode  = 1'b0;
  logic [11:0] d_query = '0;
  logic        d_valid = 1'b0;
  logic [2:0]  d_sym   = '0;
  logic        d_last  = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wf_align_array_if #(.N_PE(4), .SYM_W(3), .SCORE_W(8)) if0 ();
  wf_align_array_if #(.N_PE(4), .SYM_W(3), .SCORE_W(4)) if1 ();
  wf_align_array_if #(.N_PE(4), .SYM_W(3), .SCORE_W(8)) if2 ();

  assign if0.start = d_start;  assign if0.mode = d_mode;  assign if0.query = d_query;
  assign if0.ref_valid = d_valid;  assign if0.ref_sym = d_sym;  assign if0.ref_last = d_last;
  assign if1.start = d_start;  assign if1.mode = d_mode;  assign if1.query = d_query;
  assign if1.ref_valid = d_valid;  assign if1.ref_sym = d_sym;  assign if1.ref_last = d_last;
  assign if2.start = d_start;  assign if2.mode = d_mode;  assign if2.query = d_query;
  assign if2.ref_valid = d_valid;  assign if2.ref_sym = d_sym;  assign if2.ref_last = d_last;

  wf_align_array u0 (.clk(clk), .reset(rst_n), .bus(if0));
  wf_align_array #(.SCORE_W(4), .GAP_COST(3)) u1 (.clk(clk), .reset(rst_n), .bus(if1));
  wf_align_array #(.MAX_REF(6)) u2 (.clk(clk), .reset(rst_n), .bus(if2));

  function automatic logic obs_done(input int s);
    return (s == 0) ? if0.done : (s == 1) ? if1.done : if2.done;
  endfunction
  function automatic logic obs_ready(input int s);
    return (s == 0) ? if0.ref_ready : (s == 1) ? if1.ref_ready : if2.ref_ready;
  endfunction
  function automatic logic obs_sat(input int s);
    return (s == 0) ? if0.sat : (s == 1) ? if1.sat : if2.sat;
  endfunction
  function automatic logic [7:0] obs_score(input int s);
    return (s == 0) ? if0.score : (s == 1) ? 8'(if1.score) : if2.score;
  endfunction

  function automatic logic [2:0] nt(input byte c);
    case (c)
      "A":     return NT_A;
      "C":     return NT_C;
      "G":     return NT_G;
      "T":     return NT_T;
      default: return NT_N;
    endcase
  endfunction

  function automatic logic [11:0] qpack(input string s);
    logic [11:0] q;
    q = '0;
    for (int j = 0; j < 4; j++) q[j*3 +: 3] = nt(s[j]);
    return q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while ((if0.busy || if1.busy || if2.busy) && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check({tag, ".idle"}, 32'(if0.busy | if1.busy | if2.busy), 32'd0);
    @(posedge clk); #1;
  endtask

  // Streams rs one beat per cycle (optionally with a bubble before each beat after the first)
  // and checks done latency, score and sat on the selected instance.
  task automatic run_job(input string tag, input int sel, input logic m, input string qs,
                         input string rs, input bit bubbles, input bit last_en,
                         input bit poke_start, input int exp_score, input bit exp_sat,
                         input int exp_lat);
    int lat = 0;
    d_start = 1'b1;
    d_mode  = m;
    d_query = qpack(qs);
    @(posedge clk); #1;
    d_start = 1'b0;
    check({tag, ".ready_up"}, 32'(obs_ready(sel)), 32'd1);
    for (int k = 0; k < rs.len(); k++) begin
      if (bubbles && k > 0) begin
        d_valid = 1'b0;
        d_start = poke_start && (k == 1);
        @(posedge clk); #1;
        d_start = 1'b0;
      end
      d_valid = 1'b1;
      d_sym   = nt(rs[k]);
      d_last  = last_en && (k == rs.len() - 1);
      @(posedge clk); #1;
    end
    d_valid = 1'b0;
    d_last  = 1'b0;
    check({tag, ".ready_down"}, 32'(obs_ready(sel)), 32'd0);
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (obs_done(sel)) lat = c;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".score"}, 32'(obs_score(sel)), 32'(exp_score));
    check({tag, ".sat"}, 32'(obs_sat(sel)), 32'(exp_sat));
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(obs_done(sel)), 32'd0);
    wait_idle(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.ready", 32'(if0.ref_ready), 32'd0);
    check("rst.busy", 32'(if0.busy), 32'd0);
    check("rst.done", 32'(if0.done), 32'd0);
    check("rst.score", 32'(if0.score), 32'd0);
    check("rst.sat", 32'(if0.sat), 32'd0);
    check("rst.state", 32'(if0.state_dbg), 32'(ST_IDLE));

    run_job("g_acgt",   0, 1'b0, "ACGT", "ACGT",     0, 1, 0, 0, 0, 4);
    run_job("g_acgt2",  0, 1'b0, "ACGT", "ACGTACGT", 0, 1, 0, 4, 0, 4);
    run_job("g_aggt",   0, 1'b0, "ACGT", "AGGT",     0, 1, 0, 1, 0, 4);
    run_job("s_ttacg",  0, 1'b1, "ACGT", "TTACGTTT", 0, 1, 0, 0, 0, 4);
    run_job("g_ttacg",  0, 1'b0, "ACGT", "TTACGTTT", 0, 1, 0, 4, 0, 4);
    run_job("g_bubble", 0, 1'b0, "ACGT", "ACGTACGT", 1, 1, 1, 4, 0, 4);

    run_job("sat4", 1, 1'b0, "AAAA", "CCCCCCCC", 0, 1, 0, 15, 1, 4);
    check("sat4.wide_score", 32'(if0.score), 32'd8);
    check("sat4.wide_sat", 32'(if0.sat), 32'd0);

    // Beat 7 carries ref_last for the other instances; the MAX_REF=6 one never sees it.
    run_job("maxref", 2, 1'b0, "ACGT", "ACGTACG", 0, 1, 0, 2, 1, 3);
    check("maxref.full_score", 32'(if0.score), 32'd3);
    check("maxref.full_sat", 32'(if0.sat), 32'd0);

    d_start = 1'b1;
    d_mode  = 1'b0;
    d_query = qpack("AAAA");
    @(posedge clk); #1;
    d_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      d_valid = 1'b1;
      d_sym   = NT_C;
      @(posedge clk); #1;
    end
    check("abort.pre_sat", 32'(if1.sat), 32'd1);
    check("abort.pre_busy", 32'(if1.busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort.state", 32'(if1.state_dbg), 32'(ST_IDLE));
    check("abort.busy", 32'(if1.busy), 32'd0);
    check("abort.ready", 32'(if1.ref_ready), 32'd0);
    check("abort.done", 32'(if1.done), 32'd0);
    check("abort.score", 32'(if1.score), 32'd0);
    check("abort.sat", 32'(if1.sat), 32'd0);
    check("abort.state0", 32'(if0.state_dbg), 32'(ST_IDLE));
    rst_n   = 1'b1;
    d_valid = 1'b0;
    @(posedge clk); #1;

    run_job("post_abort", 0, 1'b0, "ACGT", "ACGT", 0, 1, 0, 0, 0, 4);
    check("post_abort.s1_score", 32'(if1.score), 32'd0);
    check("post_abort.s1_sat", 32'(if1.sat), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
